// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU time-sharing controller.
// Holds the FSM encoding, ALU command/shift codes and datapath field widths.
package alu_share_pkg;

  localparam int DATA_W  = 32;
  localparam int CMD_W   = 4;
  localparam int FLAGS_W = 4;
  localparam int SH_W    = 2;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CMD_W-1:0] CMD_AND   = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_XOR   = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ADD   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_ADC   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_SBC   = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_RSB   = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_SHIFT = 4'b1101;

  localparam logic [SH_W-1:0] SH_LSL = 2'b00;
  localparam logic [SH_W-1:0] SH_LSR = 2'b01;
  localparam logic [SH_W-1:0] SH_ASR = 2'b10;
  localparam logic [SH_W-1:0] SH_ROR = 2'b11;

  // Next requester index with wrap, so non-power-of-2 counts never leave the legal range.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
// Produces a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  int   j;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one single-cycle ALU between NUM_REQ requesters (IDLE -> EXEC -> RESP),
// with round-robin arbitration and a private NZCV register per requester.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  logic [DATA_W*NUM_REQ-1:0]  req_a_in,
  input  logic [DATA_W*NUM_REQ-1:0]  req_b_in,
  input  logic [CMD_W*NUM_REQ-1:0]   req_cmd_in,
  input  logic [SH_W*NUM_REQ-1:0]    req_sh_in,
  input  logic [SHAMT_W*NUM_REQ-1:0] req_shamt5_in,
  input  logic [NUM_REQ-1:0]         req_i_in,
  input  logic [NUM_REQ-1:0]         req_s_in,
  input  logic [NUM_REQ-1:0]         flag_clr_in,
  output logic [DATA_W-1:0]          alu_a_out,
  output logic [DATA_W-1:0]          alu_b_out,
  output logic [CMD_W-1:0]           alu_cmd_out,
  output logic [SH_W-1:0]            alu_sh_out,
  output logic [SHAMT_W-1:0]         alu_shamt5_out,
  output logic                       alu_i_out,
  output logic                       alu_s_out,
  input  logic [DATA_W-1:0]          alu_result_in,
  input  logic [FLAGS_W-1:0]         alu_nzcv_in,
  output logic                       resp_valid_out,
  input  logic                       resp_ready_in,
  output logic [ID_W-1:0]            resp_id_out,
  output logic [DATA_W-1:0]          resp_result_out,
  output logic [FLAGS_W-1:0]         resp_nzcv_out,
  output logic [FLAGS_W*NUM_REQ-1:0] flags_out
);

  state_t                     state;
  logic [ID_W-1:0]            ptr;
  logic [ID_W-1:0]            owner;
  logic [ID_W-1:0]            gnt_idx;
  logic [NUM_REQ-1:0]         gnt;
  logic                       accept;
  int                         sel;
  int                         owner_sel;

  logic [DATA_W-1:0]          a_q;
  logic [DATA_W-1:0]          b_q;
  logic [CMD_W-1:0]           cmd_q;
  logic [SH_W-1:0]            sh_q;
  logic [SHAMT_W-1:0]         shamt_q;
  logic                       i_q;
  logic                       alu_s_q;
  logic [DATA_W-1:0]          result_q;
  logic [FLAGS_W-1:0]         nzcv_q;
  logic                       resp_vld_q;
  logic [FLAGS_W*NUM_REQ-1:0] flags_q;
  logic [FLAGS_W-1:0]         owner_flags;
  logic [FLAGS_W-1:0]         upd_nzcv;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid_in),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Gated by rst_n_in so the grant is also forced low while reset is held.
  assign req_ready_out = (state == ST_IDLE && rst_n_in) ? gnt : '0;
  assign accept        = |(req_valid_in & req_ready_out);

  always_comb begin
    sel         = int'(gnt_idx);
    owner_sel   = int'(owner);
    owner_flags = flags_q[FLAGS_W*owner_sel +: FLAGS_W];
    upd_nzcv    = alu_s_q ? alu_nzcv_in
                          : (flag_clr_in[owner_sel] ? '0 : owner_flags);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      sh_q       <= '0;
      shamt_q    <= '0;
      i_q        <= 1'b0;
      alu_s_q    <= 1'b0;
      result_q   <= '0;
      nzcv_q     <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= req_a_in[DATA_W*sel +: DATA_W];
            b_q     <= req_b_in[DATA_W*sel +: DATA_W];
            cmd_q   <= req_cmd_in[CMD_W*sel +: CMD_W];
            sh_q    <= req_sh_in[SH_W*sel +: SH_W];
            shamt_q <= req_shamt5_in[SHAMT_W*sel +: SHAMT_W];
            i_q     <= req_i_in[sel];
            alu_s_q <= req_s_in[sel];
            owner   <= gnt_idx;
            ptr     <= ID_W'(wrap_inc(sel, NUM_REQ));
            state   <= ST_EXEC;
          end
        end
        // EXEC -> RESP: capture the ALU outputs in the single execute cycle
        ST_EXEC: begin
          result_q   <= alu_result_in;
          nzcv_q     <= upd_nzcv;
          alu_s_q    <= 1'b0;
          resp_vld_q <= 1'b1;
          state      <= ST_RESP;
        end
        // RESP -> IDLE: hold the response until it is accepted
        ST_RESP: begin
          if (resp_ready_in) begin
            resp_vld_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // An EXEC update of the owner's register takes priority over a coincident clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (state == ST_EXEC && alu_s_q && owner == ID_W'(i))
          flags_q[FLAGS_W*i +: FLAGS_W] <= alu_nzcv_in;
        else if (flag_clr_in[i])
          flags_q[FLAGS_W*i +: FLAGS_W] <= '0;
      end
    end
  end

  assign alu_a_out       = a_q;
  assign alu_b_out       = b_q;
  assign alu_cmd_out     = cmd_q;
  assign alu_sh_out      = sh_q;
  assign alu_shamt5_out  = shamt_q;
  assign alu_i_out       = i_q;
  assign alu_s_out       = alu_s_q;
  assign resp_valid_out  = resp_vld_q;
  assign resp_id_out     = owner;
  assign resp_result_out = result_q;
  assign resp_nzcv_out   = nzcv_q;
  assign flags_out       = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an adder ALU stub that always reports nzcv=0110.
module tb_alu_share_ctrl;

  localparam int NR = 2;
  localparam int IW = 2;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [NR-1:0]   req_valid_in;
  logic [NR-1:0]   req_ready_out;
  logic [32*NR-1:0] req_a_in, req_b_in;
  logic [4*NR-1:0] req_cmd_in;
  logic [2*NR-1:0] req_sh_in;
  logic [5*NR-1:0] req_shamt5_in;
  logic [NR-1:0]   req_i_in, req_s_in, flag_clr_in;
  logic [31:0]     alu_a_out, alu_b_out;
  logic [3:0]      alu_cmd_out;
  logic [1:0]      alu_sh_out;
  logic [4:0]      alu_shamt5_out;
  logic            alu_i_out, alu_s_out;
  logic [31:0]     alu_result_in;
  logic [3:0]      alu_nzcv_in;
  logic            resp_valid_out, resp_ready_in;
  logic [IW-1:0]   resp_id_out;
  logic [31:0]     resp_result_out;
  logic [3:0]      resp_nzcv_out;
  logic [4*NR-1:0] flags_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  assign alu_result_in = alu_a_out + alu_b_out;
  assign alu_nzcv_in   = 4'b0110;

  alu_share_ctrl #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_a_in(req_a_in), .req_b_in(req_b_in), .req_cmd_in(req_cmd_in),
    .req_sh_in(req_sh_in), .req_shamt5_in(req_shamt5_in),
    .req_i_in(req_i_in), .req_s_in(req_s_in), .flag_clr_in(flag_clr_in),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_cmd_out(alu_cmd_out),
    .alu_sh_out(alu_sh_out), .alu_shamt5_out(alu_shamt5_out),
    .alu_i_out(alu_i_out), .alu_s_out(alu_s_out),
    .alu_result_in(alu_result_in), .alu_nzcv_in(alu_nzcv_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_id_out(resp_id_out), .resp_result_out(resp_result_out),
    .resp_nzcv_out(resp_nzcv_out), .flags_out(flags_out)
  );

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a_in[32*r +: 32]    = a;
    req_b_in[32*r +: 32]    = b;
    req_cmd_in[4*r +: 4]    = 4'b0100;
    req_sh_in[2*r +: 2]     = 2'b10;
    req_shamt5_in[5*r +: 5] = 5'd3;
    req_i_in[r]             = 1'b1;
    req_s_in[r]             = s;
  endtask

  initial begin
    vecs[0] = '{r: 0, a: 32'd5,         b: 32'd7,  s: 1'b1, res: 32'd12,    nzcv: 4'b0110, flags: 8'h06};
    vecs[1] = '{r: 1, a: 32'd1,         b: 32'd1,  s: 1'b0, res: 32'd2,     nzcv: 4'b0000, flags: 8'h06};
    vecs[2] = '{r: 1, a: 32'hFFFFFFFF,  b: 32'd1,  s: 1'b1, res: 32'd0,     nzcv: 4'b0110, flags: 8'h66};
    vecs[3] = '{r: 0, a: 32'h100,       b: 32'h23, s: 1'b0, res: 32'h123,   nzcv: 4'b0110, flags: 8'h66};

    rst_n_in = 1'b0;
    req_valid_in = 2'b11; req_a_in = '0; req_b_in = '0; req_cmd_in = '0;
    req_sh_in = '0; req_shamt5_in = '0; req_i_in = '0; req_s_in = '0;
    flag_clr_in = '0; resp_ready_in = 1'b0;
    #3;
    chk("rst_ready", 64'(req_ready_out), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid_out), 64'h0);
    chk("rst_flags", 64'(flags_out), 64'h0);
    chk("rst_alu_a", 64'(alu_a_out), 64'h0);
    chk("rst_alu_s", 64'(alu_s_out), 64'h0);
    chk("rst_result", 64'(resp_result_out), 64'h0);
    step(); step();
    rst_n_in = 1'b1;
    req_valid_in = '0;

    for (int v = 0; v < 4; v++) begin
      drive(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].s);
      req_valid_in = NR'(1) << vecs[v].r;
      #1;
      chk("vec_ready", 64'(req_ready_out), 64'(NR'(1) << vecs[v].r));
      step();
      req_valid_in = '0;
      #1;
      chk("vec_exec_a", 64'(alu_a_out), 64'(vecs[v].a));
      chk("vec_exec_b", 64'(alu_b_out), 64'(vecs[v].b));
      chk("vec_exec_s", 64'(alu_s_out), 64'(vecs[v].s));
      chk("vec_exec_ctl", 64'({alu_cmd_out, alu_sh_out, alu_shamt5_out, alu_i_out}),
          64'({4'b0100, 2'b10, 5'd3, 1'b1}));
      chk("vec_exec_noresp", 64'(resp_valid_out), 64'h0);
      step();
      chk("vec_resp_valid", 64'(resp_valid_out), 64'h1);
      chk("vec_resp_id", 64'(resp_id_out), 64'(vecs[v].r));
      chk("vec_resp_result", 64'(resp_result_out), 64'(vecs[v].res));
      chk("vec_resp_nzcv", 64'(resp_nzcv_out), 64'(vecs[v].nzcv));
      chk("vec_flags", 64'(flags_out), 64'(vecs[v].flags));
      chk("vec_resp_alu_s", 64'(alu_s_out), 64'h0);
      chk("vec_resp_alu_a_hold", 64'(alu_a_out), 64'(vecs[v].a));
      resp_ready_in = 1'b1;
      step();
      resp_ready_in = 1'b0;
      #1;
      chk("vec_idle_noresp", 64'(resp_valid_out), 64'h0);
    end

    // Standalone clear of requester 0.
    flag_clr_in = 2'b01;
    step();
    flag_clr_in = '0;
    #1;
    chk("clr_alone", 64'(flags_out), 64'h60);

    // Backpressure on a requester-1 op while both requesters are waiting.
    drive(1, 32'd3, 32'd4, 1'b0);
    req_valid_in = 2'b10;
    #1;
    chk("bp_grant1", 64'(req_ready_out), 64'h2);
    step();
    req_valid_in = '0;
    step();
    drive(0, 32'd2, 32'd2, 1'b1);
    req_valid_in = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 64'(resp_valid_out), 64'h1);
      chk("bp_id", 64'(resp_id_out), 64'h1);
      chk("bp_result", 64'(resp_result_out), 64'd7);
      chk("bp_nzcv", 64'(resp_nzcv_out), 64'h6);
      chk("bp_ready_low", 64'(req_ready_out), 64'h0);
      step();
    end
    resp_ready_in = 1'b1;
    #1;
    step();
    resp_ready_in = 1'b0;
    req_valid_in = 2'b01;
    #1;
    chk("bp_next_grant", 64'(req_ready_out), 64'h1);
    step();
    // EXEC of an S=1 op on requester 0 with a coincident clear.
    req_valid_in = '0;
    flag_clr_in = 2'b01;
    #1;
    chk("coll_exec_s", 64'(alu_s_out), 64'h1);
    step();
    chk("coll_update_wins", 64'(flags_out), 64'h66);
    chk("coll_resp_nzcv", 64'(resp_nzcv_out), 64'h6);
    chk("coll_resp_result", 64'(resp_result_out), 64'd4);
    step();
    flag_clr_in = '0;
    #1;
    chk("resp_clear_flags", 64'(flags_out), 64'h60);
    chk("resp_clear_nzcv_kept", 64'(resp_nzcv_out), 64'h6);
    chk("resp_clear_valid", 64'(resp_valid_out), 64'h1);
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;

    // Reset asserted during EXEC of a requester-1 op.
    drive(1, 32'd9, 32'd9, 1'b1);
    req_valid_in = 2'b10;
    #1;
    chk("mid_grant", 64'(req_ready_out), 64'h2);
    step();
    req_valid_in = 2'b11;
    rst_n_in = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready_out), 64'h0);
    chk("mid_alu_a", 64'(alu_a_out), 64'h0);
    chk("mid_alu_s", 64'(alu_s_out), 64'h0);
    chk("mid_alu_cmd", 64'(alu_cmd_out), 64'h0);
    chk("mid_resp_valid", 64'(resp_valid_out), 64'h0);
    chk("mid_flags", 64'(flags_out), 64'h0);
    chk("mid_id_result", 64'({resp_id_out, resp_result_out, resp_nzcv_out}), 64'h0);
    step();
    rst_n_in = 1'b1;
    req_valid_in = '0;
    #1;
    chk("post_rst_noresp0", 64'(resp_valid_out), 64'h0);
    step();
    chk("post_rst_noresp1", 64'(resp_valid_out), 64'h0);

    // Round robin with both requesters continuously valid and resp_ready tied high.
    drive(0, 32'd10, 32'd1, 1'b0);
    drive(1, 32'd20, 32'd2, 1'b0);
    req_valid_in = 2'b11;
    resp_ready_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0)
        chk("rr_grant", 64'(req_ready_out), ((c / 3) % 2 == 0) ? 64'h1 : 64'h2);
      else
        chk("rr_no_grant", 64'(req_ready_out), 64'h0);
      if (c % 3 == 2) begin
        chk("rr_resp_valid", 64'(resp_valid_out), 64'h1);
        chk("rr_resp_id", 64'(resp_id_out), ((c / 3) % 2 == 0) ? 64'h0 : 64'h1);
        chk("rr_resp_result", 64'(resp_result_out), ((c / 3) % 2 == 0) ? 64'd11 : 64'd22);
        chk("rr_resp_nzcv", 64'(resp_nzcv_out), 64'h0);
      end else begin
        chk("rr_resp_idle", 64'(resp_valid_out), 64'h0);
      end
      step();
    end
    req_valid_in = '0;
    resp_ready_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
